i2s_mic_rx: RTL

I2S_MIC_RX -- requirements
Module: i2s_mic_rx

---
 rtl/i2s_mic_rx_pkg.sv | 19 +
 rtl/i2s_mic_rx_clkgen.sv | 71 +++++++
 rtl/i2s_mic_rx.sv | 118 +++++++++++
 3 files changed

// File: rtl/i2s_mic_rx_pkg.sv
// Shared constants for the I2S microphone front end: Q-formats shared with the
// adaptive FIR, I2S slot/frame geometry and the receiver state encoding.
package i2s_mic_rx_pkg;

  localparam int FIR_NB_DATA  = 21;
  localparam int FIR_NBF_DATA = 20;
  localparam int I2S_NB_WORD  = 24;

  localparam int SLOT_BITS   = 32;
  localparam int FRAME_BITS  = 2 * SLOT_BITS;
  localparam int BIT_IDX_W   = $clog2(SLOT_BITS);
  localparam int FRAME_IDX_W = $clog2(FRAME_BITS);

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

endpackage

// File: rtl/i2s_mic_rx_clkgen.sv
// I2S master bit clock and word select generator; flags the cycle on which
// bclk falls and reports the bit index within the current slot.
module i2s_clkgen
  import i2s_mic_rx_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_run,
  output logic                 o_bclk,
  output logic                 o_lrclk,
  output logic                 o_fall,
  output logic [BIT_IDX_W-1:0] o_bit_idx
);

  localparam logic [7:0]             DIV_LAST    = 8'(CLK_DIV - 1);
  localparam logic [FRAME_IDX_W-1:0] FRAME_LAST  = FRAME_IDX_W'(FRAME_BITS - 1);
  localparam logic [FRAME_IDX_W-1:0] RIGHT_FIRST = FRAME_IDX_W'(SLOT_BITS);

  logic [7:0]             div_q, div_d;
  logic                   bclk_q, bclk_d;
  logic                   lrclk_q, lrclk_d;
  logic [FRAME_IDX_W-1:0] frame_q, frame_d;
  logic                   fall;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      div_q   <= '0;
      bclk_q  <= 1'b0;
      lrclk_q <= 1'b0;
      frame_q <= '0;
    end else begin
      div_q   <= div_d;
      bclk_q  <= bclk_d;
      lrclk_q <= lrclk_d;
      frame_q <= frame_d;
    end
  end

  // frame_q counts bclk periods across both slots; its wrap is the frame boundary
  always_comb begin
    div_d   = div_q;
    bclk_d  = bclk_q;
    lrclk_d = lrclk_q;
    frame_d = frame_q;
    fall    = 1'b0;
    if (!i_run) begin
      div_d   = '0;
      bclk_d  = 1'b0;
      lrclk_d = 1'b0;
      frame_d = '0;
    end else if (div_q == DIV_LAST) begin
      div_d  = '0;
      bclk_d = ~bclk_q;
      if (bclk_q) begin
        fall    = 1'b1;
        frame_d = (frame_q == FRAME_LAST) ? '0 : frame_q + FRAME_IDX_W'(1);
        lrclk_d = (frame_d >= RIGHT_FIRST);
      end
    end else begin
      div_d = div_q + 8'd1;
    end
  end

  assign o_bclk    = bclk_q;
  assign o_lrclk   = lrclk_q;
  assign o_fall    = fall;
  assign o_bit_idx = frame_q[BIT_IDX_W-1:0];

endmodule

// File: rtl/i2s_mic_rx.sv
// Stereo I2S microphone receiver: generates bclk/lrclk, captures both slots and
// converts each 24-bit word to the FIR's rounded, saturated Q(21,20) format.
module i2s_mic_rx
  import i2s_mic_rx_pkg::*;
#(
  parameter int NB_DATA  = FIR_NB_DATA,
  parameter int NBF_DATA = FIR_NBF_DATA,
  parameter int NB_I2S   = I2S_NB_WORD,
  parameter int CLK_DIV  = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_enable,
  input  logic                      i_sdata,
  output logic                      o_bclk,
  output logic                      o_lrclk,
  output logic signed [NB_DATA-1:0] o_mic1,
  output logic signed [NB_DATA-1:0] o_mic2,
  output logic                      o_valid
);

  localparam int SHIFT   = NB_I2S - NBF_DATA - 1;
  localparam int RND     = 1 << (SHIFT - 1);
  localparam int SAT_MAX = (1 << (NB_DATA - 1)) - 1;
  localparam int SAT_MIN = -(1 << (NB_DATA - 1));
  localparam logic [BIT_IDX_W-1:0] LAST_DATA_BIT = BIT_IDX_W'(NB_I2S);
  localparam logic [BIT_IDX_W-1:0] SLOT_LAST     = BIT_IDX_W'(SLOT_BITS - 1);

  state_t                      state_q, state_d;
  logic [1:0]                  sync_q, sync_d;
  logic [NB_I2S-1:0]           shift_q, shift_d;
  logic [NB_I2S-1:0]           left_q, left_d;
  logic signed [NB_DATA-1:0]   mic1_q, mic1_d;
  logic signed [NB_DATA-1:0]   mic2_q, mic2_d;
  logic                        valid_q, valid_d;

  logic                        bclk, lrclk, fall, frame_end;
  logic [BIT_IDX_W-1:0]        bit_idx;

  // Round half up, arithmetic shift, then clamp into the output range
  function automatic logic signed [NB_DATA-1:0] to_q(input logic [NB_I2S-1:0] word);
    int acc;
    acc = int'($signed(word)) + RND;
    acc = acc >>> SHIFT;
    if (acc > SAT_MAX)      acc = SAT_MAX;
    else if (acc < SAT_MIN) acc = SAT_MIN;
    return $signed(NB_DATA'(acc));
  endfunction

  i2s_clkgen #(
    .CLK_DIV (CLK_DIV)
  ) u_clkgen (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_run     (state_q == ST_RUN),
    .o_bclk    (bclk),
    .o_lrclk   (lrclk),
    .o_fall    (fall),
    .o_bit_idx (bit_idx)
  );

  assign frame_end = fall && lrclk && (bit_idx == SLOT_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      sync_q  <= '0;
      shift_q <= '0;
      left_q  <= '0;
      mic1_q  <= '0;
      mic2_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      shift_q <= shift_d;
      left_q  <= left_d;
      mic1_q  <= mic1_d;
      mic2_q  <= mic2_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (i_enable) state_d = ST_RUN;
      ST_RUN:  if (frame_end && !i_enable) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Bit 0 of each slot is the I2S one-bit delay; bits past the word are padding
  always_comb begin
    sync_d  = {sync_q[0], i_sdata};
    shift_d = shift_q;
    left_d  = left_q;
    mic1_d  = mic1_q;
    mic2_d  = mic2_q;
    valid_d = 1'b0;
    if (fall && (bit_idx != '0) && (bit_idx <= LAST_DATA_BIT)) begin
      shift_d = {shift_q[NB_I2S-2:0], sync_q[1]};
      if (!lrclk && (bit_idx == LAST_DATA_BIT)) left_d = shift_d;
    end
    if (frame_end) begin
      mic1_d  = to_q(left_q);
      mic2_d  = to_q(shift_q);
      valid_d = 1'b1;
    end
  end

  assign o_bclk  = bclk;
  assign o_lrclk = lrclk;
  assign o_mic1  = mic1_q;
  assign o_mic2  = mic2_q;
  assign o_valid = valid_q;

endmodule
